// File: rtl/predictor_mvmult_row_driver.sv
// predictor_mvmult_row_driver
// Initiator for an ap_ctrl_hs two-row matrix-vector core. It takes one operand beat,
// launches the core, captures both row results on their ap_vld strobes, and returns
// them as one output beat. A watchdog aborts the transaction if the core never finishes.
// Optional build macro PREDICTOR_DRV_LATENCY_EN adds the last_latency[15:0] output,
// which reports the launch-to-done cycle count of the last successful transaction.
module predictor_mvmult_row_driver #(
  parameter int DATA_W      = 64,
  parameter int BIAS_W      = 96,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [BIAS_W-1:0] in_bias,
  output logic              core_start,
  input  logic              core_ready,
  input  logic              core_done,
  input  logic              core_idle,
  output logic [DATA_W-1:0] core_x,
  output logic [BIAS_W-1:0] core_bias,
  input  logic [DATA_W-1:0] core_y0,
  input  logic              core_y0_vld,
  input  logic [DATA_W-1:0] core_y1,
  input  logic              core_y1_vld,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y0,
  output logic [DATA_W-1:0] out_y1,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_missing
`ifdef PREDICTOR_DRV_LATENCY_EN
  ,
  output logic [15:0]       last_latency
`endif
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] core_x_q, core_x_d;
  logic [BIAS_W-1:0] core_bias_q, core_bias_d;
  logic [DATA_W-1:0] y0_q, y0_d, y1_q, y1_d;
  logic              f0_q, f0_d, f1_q, f1_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_missing_q, err_missing_d;
`ifdef PREDICTOR_DRV_LATENCY_EN
  logic [15:0]       lat_q, lat_d;
  logic [31:0]       lat_full;
`endif

  logic accept;
  logic active;
  logic complete;
  logic expire;

  // core_idle is status only; nothing in the control path depends on it
  logic core_idle_unused;
  assign core_idle_unused = core_idle;

  assign accept   = (state_q == S_IDLE) && in_valid && !ap_rst;
  assign active   = (state_q == S_LAUNCH) || (state_q == S_WAIT);
  // done only counts in LAUNCH when the core also acknowledges the start that cycle
  assign complete = ((state_q == S_WAIT) && core_done) ||
                    ((state_q == S_LAUNCH) && core_ready && core_done);
  // completion in the expiry cycle takes priority over the watchdog
  assign expire   = active && (timer_q == TIMER_LAST) && !complete;

  // State register and all datapath flops, synchronous reset
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= S_IDLE;
      core_x_q      <= '0;
      core_bias_q   <= '0;
      y0_q          <= '0;
      y1_q          <= '0;
      f0_q          <= 1'b0;
      f1_q          <= 1'b0;
      timer_q       <= '0;
      err_timeout_q <= 1'b0;
      err_missing_q <= 1'b0;
`ifdef PREDICTOR_DRV_LATENCY_EN
      lat_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      core_x_q      <= core_x_d;
      core_bias_q   <= core_bias_d;
      y0_q          <= y0_d;
      y1_q          <= y1_d;
      f0_q          <= f0_d;
      f1_q          <= f1_d;
      timer_q       <= timer_d;
      err_timeout_q <= err_timeout_d;
      err_missing_q <= err_missing_d;
`ifdef PREDICTOR_DRV_LATENCY_EN
      lat_q         <= lat_d;
`endif
    end
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_LAUNCH;
      S_LAUNCH: begin
        if (complete)        state_d = S_HOLD;
        else if (expire)     state_d = S_IDLE;
        else if (core_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (complete)        state_d = S_HOLD;
        else if (expire)     state_d = S_IDLE;
      end
      S_HOLD:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Operand latch, result capture, watchdog timer and sticky error flags
  always_comb begin
    core_x_d      = core_x_q;
    core_bias_d   = core_bias_q;
    y0_d          = y0_q;
    y1_d          = y1_q;
    f0_d          = f0_q;
    f1_d          = f1_q;
    timer_d       = timer_q;
    err_timeout_d = err_timeout_q;
    err_missing_d = err_missing_q;
`ifdef PREDICTOR_DRV_LATENCY_EN
    lat_d         = lat_q;
    lat_full      = 32'(timer_q) + 32'd1;
`endif
    if (accept) begin
      // a fresh beat clears the previous results so a missing lane reads as zero
      core_x_d    = in_x;
      core_bias_d = in_bias;
      y0_d        = '0;
      y1_d        = '0;
      f0_d        = 1'b0;
      f1_d        = 1'b0;
      timer_d     = '0;
    end
    if (active) begin
      timer_d = timer_q + TW'(1);
      if (core_y0_vld) begin
        y0_d = core_y0;
        f0_d = 1'b1;
      end
      if (core_y1_vld) begin
        y1_d = core_y1;
        f1_d = 1'b1;
      end
      if (complete && !(f0_d && f1_d)) err_missing_d = 1'b1;
      if (expire) err_timeout_d = 1'b1;
`ifdef PREDICTOR_DRV_LATENCY_EN
      // timer counts from the first core_start cycle, so done-cycle latency is timer+1
      if (complete) lat_d = (lat_full > 32'h0000_FFFF) ? 16'hFFFF : lat_full[15:0];
`endif
    end
  end

  // Outputs decoded from state and registered datapath
  always_comb begin
    in_ready    = (state_q == S_IDLE) && !ap_rst;
    core_start  = (state_q == S_LAUNCH);
    out_valid   = (state_q == S_HOLD);
    busy        = (state_q != S_IDLE);
    core_x      = core_x_q;
    core_bias   = core_bias_q;
    out_y0      = y0_q;
    out_y1      = y1_q;
    err_timeout = err_timeout_q;
    err_missing = err_missing_q;
`ifdef PREDICTOR_DRV_LATENCY_EN
    last_latency = lat_q;
`endif
  end

endmodule

// File: tb/tb_predictor_mvmult_row_driver.sv
// Testbench for predictor_mvmult_row_driver: a scripted core model drives each
// transaction; expected results come from a last-strobe-wins reference per lane.
module tb_predictor_mvmult_row_driver;
  localparam int DW = 64;
  localparam int BW = 96;
  localparam int TO = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_x;
  logic [BW-1:0] in_bias;
  logic          core_start, core_ready, core_done, core_idle;
  logic [DW-1:0] core_x;
  logic [BW-1:0] core_bias;
  logic [DW-1:0] core_y0, core_y1;
  logic          core_y0_vld, core_y1_vld;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_y0, out_y1;
  logic          busy, err_timeout, err_missing;
`ifdef PREDICTOR_DRV_LATENCY_EN
  logic [15:0]   last_latency;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_missing = 1'b0;
  bit exp_timeout = 1'b0;
  bit pending = 1'b0;

  always #5 ap_clk = ~ap_clk;

  predictor_mvmult_row_driver #(.DATA_W(DW), .BIAS_W(BW), .TIMEOUT_CYC(TO)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_bias(in_bias),
    .core_start(core_start), .core_ready(core_ready), .core_done(core_done),
    .core_idle(core_idle), .core_x(core_x), .core_bias(core_bias),
    .core_y0(core_y0), .core_y0_vld(core_y0_vld),
    .core_y1(core_y1), .core_y1_vld(core_y1_vld),
    .out_valid(out_valid), .out_ready(out_ready), .out_y0(out_y0), .out_y1(out_y1),
    .busy(busy), .err_timeout(err_timeout), .err_missing(err_missing)
`ifdef PREDICTOR_DRV_LATENCY_EN
    , .last_latency(last_latency)
`endif
  );

  task automatic clear_core();
    core_ready = 1'b0; core_done = 1'b0;
    core_y0_vld = 1'b0; core_y1_vld = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; in_valid = 1'b0; in_x = '0; in_bias = '0; out_ready = 1'b0;
    core_idle = 1'b1; core_y0 = '0; core_y1 = '0; clear_core();
    repeat (3) @(negedge ap_clk);
    n_cmp++;
    if ({in_ready, core_start, out_valid, busy, err_timeout, err_missing} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000000",
               {in_ready, core_start, out_valid, busy, err_timeout, err_missing});
    end
    n_cmp++;
    if (core_x !== '0 || core_bias !== '0 || out_y0 !== '0 || out_y1 !== '0) begin
      n_bad++;
      $display("FAIL reset_data got x=%h b=%h y0=%h y1=%h want all 0", core_x, core_bias, out_y0, out_y1);
    end
    ap_rst = 1'b0;
    @(negedge ap_clk);
    n_cmp++;
    if ({in_ready, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_release in_ready/busy got %b want 10", {in_ready, busy});
    end
    $display("txn reset done");
  endtask

  // One full transaction: accept, scripted core responses, hold with backpressure, release
  task automatic run_txn(input logic [DW-1:0] x, input logic [BW-1:0] bias,
                         input int ready_dly, input int y0_at, input int y1_at, input int done_at,
                         input bit rnd, input int out_wait, input bit chain, input string tag);
    logic [DW-1:0] xv, ey0, ey1, d;
    logic [BW-1:0] bv;
    bit s0, s1, v, want_start;
    int starts;
    ey0 = '0; ey1 = '0; s0 = 1'b0; s1 = 1'b0; starts = 0;
    if (!pending) begin
      in_x = x; in_bias = bias; in_valid = 1'b1;
    end
    pending = 1'b0;
    xv = in_x; bv = in_bias;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s accept in_ready got %b want 1", tag, in_ready);
    end
    @(negedge ap_clk);
    in_valid = 1'b0;
    for (int k = 0; k <= done_at; k++) begin
      want_start = (k <= ready_dly);
      n_cmp++;
      if ({core_start, in_ready, out_valid, busy} !== {want_start, 1'b0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL %s run k=%0d start/in_rdy/out_vld/busy got %b want %b", tag, k,
                 {core_start, in_ready, out_valid, busy}, {want_start, 3'b001});
      end
      if (core_start === 1'b1) starts++;
      n_cmp++;
      if (core_x !== xv || core_bias !== bv) begin
        n_bad++;
        $display("FAIL %s operand k=%0d got x=%h b=%h want x=%h b=%h", tag, k, core_x, core_bias, xv, bv);
      end
      core_ready = (k == ready_dly);
      core_idle = 1'($urandom_range(0, 1));
      v = (k == y0_at) || (rnd && y0_at >= 0 && $urandom_range(0, 3) == 0);
      d = {$urandom, $urandom};
      core_y0 = d; core_y0_vld = v;
      if (v) begin ey0 = d; s0 = 1'b1; end
      v = (k == y1_at) || (rnd && y1_at >= 0 && $urandom_range(0, 3) == 0);
      d = {$urandom, $urandom};
      core_y1 = d; core_y1_vld = v;
      if (v) begin ey1 = d; s1 = 1'b1; end
      core_done = (k == done_at);
      @(negedge ap_clk);
    end
    clear_core();
    core_y0 = {$urandom, $urandom}; core_y1 = {$urandom, $urandom};
    if (!(s0 && s1)) exp_missing = 1'b1;
    n_cmp++;
    if (starts != ready_dly + 1) begin
      n_bad++;
      $display("FAIL %s start_cycles got %0d want %0d", tag, starts, ready_dly + 1);
    end
    for (int w = 0; w <= out_wait; w++) begin
      n_cmp++;
      if ({out_valid, in_ready, busy, core_start} !== 4'b1010) begin
        n_bad++;
        $display("FAIL %s hold w=%0d out_vld/in_rdy/busy/start got %b want 1010", tag, w,
                 {out_valid, in_ready, busy, core_start});
      end
      n_cmp++;
      if (out_y0 !== ey0 || out_y1 !== ey1) begin
        n_bad++;
        $display("FAIL %s result w=%0d got y0=%h y1=%h want y0=%h y1=%h", tag, w, out_y0, out_y1, ey0, ey1);
      end
      n_cmp++;
      if ({err_missing, err_timeout} !== {exp_missing, exp_timeout}) begin
        n_bad++;
        $display("FAIL %s errors got miss/to=%b want %b", tag, {err_missing, err_timeout},
                 {exp_missing, exp_timeout});
      end
      if (chain && w == 0) begin
        in_valid = 1'b1; in_x = {$urandom, $urandom}; in_bias = {$urandom, $urandom, $urandom};
      end
      out_ready = (w == out_wait);
      @(negedge ap_clk);
    end
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL %s release out_vld/in_rdy/busy got %b want 010", tag, {out_valid, in_ready, busy});
    end
`ifdef PREDICTOR_DRV_LATENCY_EN
    n_cmp++;
    if (last_latency !== 16'(done_at + 1)) begin
      n_bad++;
      $display("FAIL %s latency got %0d want %0d", tag, last_latency, done_at + 1);
    end
`endif
    if (chain) pending = 1'b1;
    $display("txn %s x=%h y0=%h y1=%h done_at=%0d", tag, xv, ey0, ey1, done_at);
  endtask

  task automatic test_single();
    run_txn(64'h0000_0001_0000_0000, '0, 0, 4, 5, 5, 1'b0, 0, 1'b0, "single");
  endtask

  task automatic test_ready_delay();
    run_txn({$urandom, $urandom}, {$urandom, $urandom, $urandom}, 3, 5, 6, 7, 1'b0, 1, 1'b0, "ready_delay");
  endtask

  task automatic test_back_to_back();
    run_txn({$urandom, $urandom}, {$urandom, $urandom, $urandom}, 1, 2, 3, 4, 1'b1, 10, 1'b1, "backpressure");
    run_txn('0, '0, 0, 1, 1, 2, 1'b0, 0, 1'b0, "chained");
  endtask

  task automatic test_random();
    int rd, da;
    for (int i = 0; i < 20; i++) begin
      rd = $urandom_range(0, 3);
      da = rd + $urandom_range(0, 11);
      run_txn({$urandom, $urandom}, {$urandom, $urandom, $urandom}, rd,
              $urandom_range(0, da), $urandom_range(0, da), da, 1'b1,
              $urandom_range(0, 3), (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0, "random");
    end
  endtask

  task automatic test_done_at_expiry();
    run_txn({$urandom, $urandom}, {$urandom, $urandom, $urandom}, 0, 3, 15, TO - 1, 1'b0, 0, 1'b0, "done_at_expiry");
  endtask

  task automatic test_missing();
    run_txn({$urandom, $urandom}, '0, 0, 2, -1, 4, 1'b0, 0, 1'b0, "missing_y1");
    run_txn({$urandom, $urandom}, '0, 0, 2, 3, 4, 1'b1, 0, 1'b0, "after_missing");
  endtask

  task automatic test_timeout();
    in_x = {$urandom, $urandom}; in_bias = {$urandom, $urandom, $urandom}; in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout accept in_ready got %b want 1", in_ready);
    end
    @(negedge ap_clk);
    in_valid = 1'b0;
    for (int k = 0; k <= TO + 1; k++) begin
      n_cmp++;
      if (err_timeout !== (k >= TO) || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout k=%0d err_timeout/out_valid got %b%b want %b0", k, err_timeout, out_valid, k >= TO);
      end
      n_cmp++;
      if ({in_ready, busy} !== ((k >= TO) ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("FAIL timeout k=%0d in_ready/busy got %b want %b", k, {in_ready, busy},
                 (k >= TO) ? 2'b10 : 2'b01);
      end
      core_ready = (k == 0);
      core_y0_vld = 1'($urandom_range(0, 1)); core_y0 = {$urandom, $urandom};
      @(negedge ap_clk);
    end
    clear_core();
    exp_timeout = 1'b1;
    $display("txn timeout err_timeout=%b", err_timeout);
  endtask

  task automatic test_reset_mid();
    in_x = {$urandom, $urandom}; in_bias = {$urandom, $urandom, $urandom}; in_valid = 1'b1;
    @(negedge ap_clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      core_ready = (k == 0);
      @(negedge ap_clk);
    end
    clear_core();
    ap_rst = 1'b1;
    @(negedge ap_clk);
    n_cmp++;
    if ({in_ready, core_start, out_valid, busy, err_timeout, err_missing} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_mid flags got %b want 000000",
               {in_ready, core_start, out_valid, busy, err_timeout, err_missing});
    end
    n_cmp++;
    if (core_x !== '0 || core_bias !== '0 || out_y0 !== '0 || out_y1 !== '0) begin
      n_bad++;
      $display("FAIL reset_mid data got x=%h b=%h y0=%h y1=%h want all 0", core_x, core_bias, out_y0, out_y1);
    end
`ifdef PREDICTOR_DRV_LATENCY_EN
    n_cmp++;
    if (last_latency !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_mid latency got %0d want 0", last_latency);
    end
`endif
    ap_rst = 1'b0;
    exp_timeout = 1'b0; exp_missing = 1'b0;
    core_done = 1'b1; core_y0_vld = 1'b1; core_y1_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge ap_clk);
      clear_core();
      n_cmp++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
        n_bad++;
        $display("FAIL reset_mid late_done k=%0d out_vld/busy/in_rdy got %b want 001", k,
                 {out_valid, busy, in_ready});
      end
    end
    $display("txn reset_mid ignored late done");
    run_txn({$urandom, $urandom}, {$urandom, $urandom, $urandom}, 1, 2, 2, 3, 1'b1, 1, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_ready_delay();
    test_back_to_back();
    test_random();
    test_done_at_expiry();
    test_missing();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "simulation time limit");
  end

endmodule
